// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback port arbiter with load formatting, 2-entry load FIFO and pending-load scoreboard
module wb_arbiter (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        Alu_Valid,
    input  logic [4:0]  Alu_DR,
    input  logic [31:0] Alu_Result,
    input  logic        Iss_Valid,
    input  logic [4:0]  Iss_DR,
    input  logic        Ld_Valid,
    output logic        Ld_Ready,
    input  logic [4:0]  Ld_DR,
    input  logic [2:0]  Ld_Funct3,
    input  logic [1:0]  Ld_Addr_Lo,
    input  logic [31:0] Ld_Data,
    output logic        RegW,
    output logic [4:0]  DR,
    output logic [31:0] Reg_In,
    output logic [31:0] Pending,
    output logic        Ld_Err
);
    logic [1:0]  count;
    logic        rd_ptr, wr_ptr;
    logic [4:0]  fifo_dr [2];
    logic [31:0] fifo_data [2];
    logic        accept, err, ld_ok, alu_w, pop, bypass, push, ld_win;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext, clr, set;
    logic [4:0]  ld_win_dr;
    assign Ld_Ready  = count < 2'd2;
    assign accept    = Ld_Valid && Ld_Ready;
    assign err       = Ld_Funct3 == 3'b011 || Ld_Funct3[2:1] == 2'b11;
    assign ld_ok     = accept && !err && Ld_DR != 5'd0;
    assign alu_w     = Alu_Valid && Alu_DR != 5'd0;
    assign pop       = !alu_w && count != 2'd0;
    assign bypass    = !alu_w && count == 2'd0 && ld_ok;
    assign push      = ld_ok && !bypass;
    assign ld_win    = pop || bypass;
    assign ld_win_dr = pop ? fifo_dr[rd_ptr] : Ld_DR;
    assign ld_byte   = Ld_Data[{Ld_Addr_Lo, 3'b000} +: 8];
    assign ld_half   = Ld_Addr_Lo[1] ? Ld_Data[31:16] : Ld_Data[15:0];
    assign ld_ext    = Ld_Funct3[1:0] == 2'b00 ? {{24{~Ld_Funct3[2] & ld_byte[7]}}, ld_byte} :
                       Ld_Funct3[1:0] == 2'b01 ? {{16{~Ld_Funct3[2] & ld_half[15]}}, ld_half} : Ld_Data;
    assign clr       = (ld_win ? 32'd1 << ld_win_dr : 32'd0) | (accept && err ? 32'd1 << Ld_DR : 32'd0);
    assign set       = Iss_Valid ? 32'd1 << Iss_DR : 32'd0;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count   <= '0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            RegW    <= 1'b0;
            DR      <= '0;
            Reg_In  <= '0;
            Pending <= '0;
            Ld_Err  <= 1'b0;
        end else begin
            count   <= count + 2'(push) - 2'(pop);
            rd_ptr  <= rd_ptr ^ pop;
            wr_ptr  <= wr_ptr ^ push;
            RegW    <= alu_w || ld_win;
            if (alu_w || ld_win) begin
                DR     <= alu_w ? Alu_DR : ld_win_dr;
                Reg_In <= alu_w ? Alu_Result : pop ? fifo_data[rd_ptr] : ld_ext;
            end
            Pending <= ((Pending & ~clr) | set) & ~32'd1;
            Ld_Err  <= accept && err;
        end
    end
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_dr[wr_ptr]   <= Ld_DR;
            fifo_data[wr_ptr] <= ld_ext;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vectors with a write-port scoreboard for wb_arbiter
module tb_wb_arbiter;
    logic        CLK = 1'b0, RST_N = 1'b0;
    logic        Alu_Valid = 1'b0, Iss_Valid = 1'b0, Ld_Valid = 1'b0;
    logic [4:0]  Alu_DR = '0, Iss_DR = '0, Ld_DR = '0;
    logic [31:0] Alu_Result = '0, Ld_Data = '0;
    logic [2:0]  Ld_Funct3 = '0;
    logic [1:0]  Ld_Addr_Lo = '0;
    logic        Ld_Ready, RegW, Ld_Err;
    logic [4:0]  DR;
    logic [31:0] Reg_In, Pending;
    int vectors = 0, miscompares = 0;
    typedef struct {logic [4:0] dr; logic [31:0] d;} wr_t;
    wr_t exp_q[$];

    wb_arbiter dut (.CLK(CLK), .RST_N(RST_N), .Alu_Valid(Alu_Valid), .Alu_DR(Alu_DR),
        .Alu_Result(Alu_Result), .Iss_Valid(Iss_Valid), .Iss_DR(Iss_DR), .Ld_Valid(Ld_Valid),
        .Ld_Ready(Ld_Ready), .Ld_DR(Ld_DR), .Ld_Funct3(Ld_Funct3), .Ld_Addr_Lo(Ld_Addr_Lo),
        .Ld_Data(Ld_Data), .RegW(RegW), .DR(DR), .Reg_In(Reg_In), .Pending(Pending), .Ld_Err(Ld_Err));

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (RST_N && RegW) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL stray_write: got DR=%0d Reg_In=%h, none expected", DR, Reg_In);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (DR !== e.dr || Reg_In !== e.d) begin
                    miscompares++;
                    $display("FAIL write: got DR=%0d Reg_In=%h, expected DR=%0d Reg_In=%h", DR, Reg_In, e.dr, e.d);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] dr, input logic [31:0] d);
        wr_t e;
        e.dr = dr;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic drive_ld(input logic [4:0] dr, input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] d);
        Ld_Valid = 1'b1;
        Ld_DR = dr;
        Ld_Funct3 = f3;
        Ld_Addr_Lo = lo;
        Ld_Data = d;
    endtask

    task automatic clear_in();
        Alu_Valid = 1'b0;
        Iss_Valid = 1'b0;
        Ld_Valid = 1'b0;
    endtask

    initial begin
        int li;
        logic acc;
        step();
        step();
        chk("reset_regw", 32'(RegW), 32'd0);
        chk("reset_dr", 32'(DR), 32'd0);
        chk("reset_reg_in", Reg_In, 32'd0);
        chk("reset_pending", Pending, 32'd0);
        chk("reset_ld_err", 32'(Ld_Err), 32'd0);
        chk("reset_ld_ready", 32'(Ld_Ready), 32'd1);
        RST_N = 1'b1;
        step();
        // single ALU write
        Alu_Valid = 1'b1; Alu_DR = 5'd5; Alu_Result = 32'h1234;
        expect_wr(5'd5, 32'h0000_1234);
        step();
        clear_in();
        chk("alu_regw_high", 32'(RegW), 32'd1);
        step();
        chk("alu_regw_low", 32'(RegW), 32'd0);
        // load formatting, all bypassed
        expect_wr(5'd1, 32'hFFFF_FFFF); drive_ld(5'd1, 3'b000, 2'd2, 32'h80FF_7F01); step();
        expect_wr(5'd2, 32'h0000_007F); drive_ld(5'd2, 3'b100, 2'd1, 32'h80FF_7F01); step();
        expect_wr(5'd3, 32'hFFFF_80FF); drive_ld(5'd3, 3'b001, 2'd3, 32'h80FF_7F01); step();
        expect_wr(5'd4, 32'h0000_7F01); drive_ld(5'd4, 3'b101, 2'd0, 32'h80FF_7F01); step();
        expect_wr(5'd6, 32'h80FF_7F01); drive_ld(5'd6, 3'b010, 2'd3, 32'h80FF_7F01); step();
        clear_in();
        step();
        chk("alu_x0_setup_ready", 32'(Ld_Ready), 32'd1);
        Alu_Valid = 1'b1; Alu_DR = 5'd0; Alu_Result = 32'hDEAD;
        step();
        clear_in();
        step();
        // collision: ALU x3 for three cycles, LW to 7,8,9 streaming
        for (int i = 0; i < 3; i++) expect_wr(5'd3, 32'h30 + i);
        for (int i = 0; i < 3; i++) expect_wr(5'd7 + 5'(i), 32'h700 + i);
        li = 0;
        for (int c = 0; c < 8; c++) begin
            Alu_Valid = c < 3; Alu_DR = 5'd3; Alu_Result = 32'h30 + c;
            Ld_Valid = li < 3; Ld_DR = 5'd7 + 5'(li); Ld_Funct3 = 3'b010; Ld_Addr_Lo = 2'd0; Ld_Data = 32'h700 + li;
            if (c == 2) chk("collision_ready_low", 32'(Ld_Ready), 32'd0);
            acc = Ld_Valid && Ld_Ready;
            step();
            if (acc) li++;
        end
        clear_in();
        chk("collision_all_accepted", li, 3);
        // scoreboard
        Iss_Valid = 1'b1; Iss_DR = 5'd0; step(); clear_in();
        chk("pending_x0", Pending, 32'd0);
        Iss_Valid = 1'b1; Iss_DR = 5'd10; step(); clear_in();
        chk("pending_set10", Pending, 32'h0000_0400);
        expect_wr(5'd10, 32'hCAFE); drive_ld(5'd10, 3'b010, 2'd0, 32'hCAFE); step(); clear_in();
        chk("pending_clr10_regw", 32'(RegW), 32'd1);
        chk("pending_clr10", Pending, 32'd0);
        step();
        chk("pending_clr10_after", Pending, 32'd0);
        Iss_Valid = 1'b1; Iss_DR = 5'd13; step();
        expect_wr(5'd13, 32'h13); drive_ld(5'd13, 3'b010, 2'd0, 32'h13); step(); clear_in();
        chk("pending_set_wins", Pending, 32'h0000_2000);
        drive_ld(5'd13, 3'b010, 2'd0, 32'h14); expect_wr(5'd13, 32'h14); step(); clear_in();
        chk("pending_clr13", Pending, 32'd0);
        // unsupported funct3
        Iss_Valid = 1'b1; Iss_DR = 5'd12; step(); clear_in();
        chk("err_pending_set", Pending, 32'h0000_1000);
        drive_ld(5'd12, 3'b011, 2'd0, 32'hBAD); step(); clear_in();
        chk("err_pulse", 32'(Ld_Err), 32'd1);
        chk("err_no_regw", 32'(RegW), 32'd0);
        chk("err_pending_clr", Pending, 32'd0);
        step();
        chk("err_pulse_end", 32'(Ld_Err), 32'd0);
        // fill FIFO then reset mid-operation
        expect_wr(5'd4, 32'h40);
        Iss_Valid = 1'b1; Iss_DR = 5'd20;
        for (int c = 0; c < 2; c++) begin
            Alu_Valid = 1'b1; Alu_DR = 5'd4; Alu_Result = 32'h40 + c;
            drive_ld(5'd20 + 5'(c), 3'b010, 2'd0, 32'h200 + c);
            step();
            Iss_Valid = 1'b0;
        end
        clear_in();
        chk("full_ready_low", 32'(Ld_Ready), 32'd0);
        chk("full_pending", Pending, 32'h0010_0000);
        RST_N = 1'b0;
        #1;
        chk("rst_regw", 32'(RegW), 32'd0);
        chk("rst_reg_in", Reg_In, 32'd0);
        chk("rst_pending", Pending, 32'd0);
        chk("rst_ready", 32'(Ld_Ready), 32'd1);
        step();
        step();
        RST_N = 1'b1;
        repeat (4) step();
        chk("post_rst_ready", 32'(Ld_Ready), 32'd1);
        chk("post_rst_pending", Pending, 32'd0);
        chk("exp_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
